// File: rtl/mmio_pkg.sv
// Shared types and constants for the CPU-side MMIO bus master.
package mmio_pkg;

    localparam int          BUS_DW    = 32;
    localparam logic [31:0] MMIO_BASE = 32'h4000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mmio_timeout_ctr.sv
// Clear/enable cycle counter; expired flags the last allowed bus-cycle clock.
module mmio_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    import mmio_pkg::*;

    localparam int             CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_r;

    // Counter: clear has priority so every bus cycle starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/mmio_bus_master.sv
// Turns one CPU load/store into a single MMIO bus cycle and reports done/error.
module mmio_bus_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic        cpu_stall_o,
    output logic        cpu_done_o,
    output logic        cpu_err_o,
    output logic [31:0] cpu_rdata_o,
    output logic        write_o,
    output logic        read_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic        ack_i
);
    import mmio_pkg::*;

    state_t state_r;
    logic   accept_s;
    logic   ack_s;
    logic   expired_s;

    assign accept_s = (state_r == IDLE) && cpu_req_i && is_word_aligned(cpu_addr_i);
    // The shared ack net may float; only a solid 1 is taken as an acknowledge.
    assign ack_s    = (ack_i == 1'b1);

    mmio_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept_s),
        .enable  (state_r == BUS),
        .expired (expired_s)
    );

    assign cpu_stall_o = ((state_r == IDLE) && cpu_req_i) || (state_r == BUS);

    // Access FSM with all bus and CPU-result outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cpu_done_o  <= 1'b0;
            cpu_err_o   <= 1'b0;
            cpu_rdata_o <= 32'h0000_0000;
            write_o     <= 1'b0;
            read_o      <= 1'b0;
            addr_o      <= 32'h0000_0000;
            data_o      <= 32'h0000_0000;
        end else begin
            cpu_done_o  <= 1'b0;
            cpu_err_o   <= 1'b0;
            cpu_rdata_o <= 32'h0000_0000;
            case (state_r)
                IDLE: begin
                    if (cpu_req_i && !is_word_aligned(cpu_addr_i)) begin
                        state_r    <= ERR;
                        cpu_done_o <= 1'b1;
                        cpu_err_o  <= 1'b1;
                    end else if (cpu_req_i) begin
                        state_r <= BUS;
                        write_o <= cpu_we_i;
                        read_o  <= ~cpu_we_i;
                        addr_o  <= cpu_addr_i;
                        data_o  <= cpu_wdata_i;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUS: begin
                    // Ack beats a simultaneous timeout.
                    if (ack_s) begin
                        state_r     <= DONE;
                        cpu_done_o  <= 1'b1;
                        cpu_rdata_o <= read_o ? data_i : 32'h0000_0000;
                        write_o     <= 1'b0;
                        read_o      <= 1'b0;
                        addr_o      <= 32'h0000_0000;
                        data_o      <= 32'h0000_0000;
                    end else if (expired_s) begin
                        state_r    <= ERR;
                        cpu_done_o <= 1'b1;
                        cpu_err_o  <= 1'b1;
                        write_o    <= 1'b0;
                        read_o     <= 1'b0;
                        addr_o     <= 32'h0000_0000;
                        data_o     <= 32'h0000_0000;
                    end else begin
                        state_r <= BUS;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                ERR: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    write_o <= 1'b0;
                    read_o  <= 1'b0;
                    addr_o  <= 32'h0000_0000;
                    data_o  <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus_master.sv
// Directed bench for mmio_bus_master with an LED slave model at 0x4000_0000.
module tb_mmio_bus_master;

    localparam logic [31:0] LED_ADDR = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_stall, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;
    logic        write_s, read_s;
    logic [31:0] addr_s, data_s, data_in;
    logic        ack_in;
    logic        force_ack = 1'b0;
    logic [31:0] force_data = 32'h0;
    logic [9:0]  ledr = 10'h0;
    logic        led_hit;

    int n_checks = 0;
    int n_fail = 0;

    int          r_done_cyc, r_rd_cnt, r_wr_cnt, r_first, r_last, r_addr_bad;
    logic        r_err, r_stall0, r_stall_done, r_post_strobe, r_post_done;
    logic [31:0] r_rdata;

    always #5 clk = ~clk;

    mmio_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_stall_o(cpu_stall), .cpu_done_o(cpu_done), .cpu_err_o(cpu_err), .cpu_rdata_o(cpu_rdata),
        .write_o(write_s), .read_o(read_s), .addr_o(addr_s), .data_o(data_s),
        .data_i(data_in), .ack_i(ack_in)
    );

    // LED slave: combinational ack, 10-bit register; bus pulled low otherwise.
    assign led_hit = (read_s || write_s) && (addr_s == LED_ADDR);
    assign ack_in  = led_hit || force_ack;
    assign data_in = (read_s && addr_s == LED_ADDR) ? {22'h0, ledr} : force_data;
    always @(posedge clk) if (write_s && addr_s == LED_ADDR) ledr <= data_s[9:0];

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_cyc, input logic perturb);
        r_done_cyc = 0; r_rd_cnt = 0; r_wr_cnt = 0; r_first = 0; r_last = 0; r_addr_bad = 0;
        r_err = 1'bx; r_rdata = 32'hx; r_stall_done = 1'bx;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        #1;
        r_stall0 = cpu_stall;
        if (read_s || write_s) r_addr_bad++;
        for (int c = 1; c <= 40 && r_done_cyc == 0; c++) begin
            @(posedge clk); #1;
            if (read_s) r_rd_cnt++;
            if (write_s) r_wr_cnt++;
            if (read_s || write_s) begin
                if (r_first == 0) r_first = c;
                r_last = c;
                if (addr_s !== addr) r_addr_bad++;
            end
            if (cpu_done) begin
                r_done_cyc = c; r_err = cpu_err; r_rdata = cpu_rdata; r_stall_done = cpu_stall;
                cpu_req = 1'b0;
            end
            force_ack = (c == ack_cyc);
            if (perturb && c == 3) begin
                cpu_addr = LED_ADDR; cpu_we = ~we;
            end
        end
        force_ack = 1'b0;
        @(posedge clk); #1;
        r_post_strobe = read_s || write_s;
        r_post_done = cpu_done;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({cpu_stall, cpu_done, cpu_err, cpu_rdata, write_s, read_s, addr_s, data_s} !== 100'h0) begin
            n_fail++; $display("FAIL reset_outputs: got stall=%b done=%b err=%b rdata=%h wr=%b rd=%b addr=%h data=%h, expected all 0",
                               cpu_stall, cpu_done, cpu_err, cpu_rdata, write_s, read_s, addr_s, data_s);
        end
        #10 rst_n = 1'b1;
    endtask

    task automatic test_store();
        do_access(1'b1, LED_ADDR, 32'h0000_02A5, 0, 1'b0);
        n_checks++; if (r_wr_cnt !== 1 || r_rd_cnt !== 0) begin n_fail++; $display("FAIL store_strobes: wr=%0d rd=%0d expected 1/0", r_wr_cnt, r_rd_cnt); end
        n_checks++; if (r_first !== 1) begin n_fail++; $display("FAIL store_strobe_cycle: got %0d expected 1", r_first); end
        n_checks++; if (r_done_cyc !== 2 || r_err !== 1'b0) begin n_fail++; $display("FAIL store_done: cyc=%0d err=%b expected 2/0", r_done_cyc, r_err); end
        n_checks++; if (ledr !== 10'h2A5) begin n_fail++; $display("FAIL store_ledr: got %h expected 2a5", ledr); end
        n_checks++; if (r_stall0 !== 1'b1 || r_stall_done !== 1'b0) begin n_fail++; $display("FAIL store_stall: c0=%b done=%b expected 1/0", r_stall0, r_stall_done); end
        n_checks++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL store_rdata: got %h expected 0", r_rdata); end
    endtask

    task automatic test_load();
        do_access(1'b0, LED_ADDR, 32'hFFFF_FFFF, 0, 1'b0);
        n_checks++; if (r_rd_cnt !== 1 || r_wr_cnt !== 0) begin n_fail++; $display("FAIL load_strobes: rd=%0d wr=%0d expected 1/0", r_rd_cnt, r_wr_cnt); end
        n_checks++; if (r_done_cyc !== 2 || r_err !== 1'b0) begin n_fail++; $display("FAIL load_done: cyc=%0d err=%b expected 2/0", r_done_cyc, r_err); end
        n_checks++; if (r_rdata !== 32'h0000_02A5) begin n_fail++; $display("FAIL load_rdata: got %h expected 000002a5", r_rdata); end
    endtask

    task automatic test_timeout();
        do_access(1'b0, 32'h5000_0000, 32'h0, 0, 1'b1);
        n_checks++; if (r_rd_cnt !== 16 || r_wr_cnt !== 0) begin n_fail++; $display("FAIL timeout_strobes: rd=%0d wr=%0d expected 16/0", r_rd_cnt, r_wr_cnt); end
        n_checks++; if (r_first !== 1 || r_last !== 16) begin n_fail++; $display("FAIL timeout_window: first=%0d last=%0d expected 1/16", r_first, r_last); end
        n_checks++; if (r_done_cyc !== 17 || r_err !== 1'b1) begin n_fail++; $display("FAIL timeout_done: cyc=%0d err=%b expected 17/1", r_done_cyc, r_err); end
        n_checks++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata: got %h expected 0", r_rdata); end
        n_checks++; if (r_addr_bad !== 0) begin n_fail++; $display("FAIL timeout_latched_addr: %0d bad cycles expected 0", r_addr_bad); end
        n_checks++; if (r_post_strobe !== 1'b0 || r_post_done !== 1'b0) begin n_fail++; $display("FAIL timeout_after: strobe=%b done=%b expected 0/0", r_post_strobe, r_post_done); end
    endtask

    task automatic test_misaligned();
        do_access(1'b1, 32'h4000_0002, 32'h0000_03FF, 0, 1'b0);
        n_checks++; if (r_rd_cnt + r_wr_cnt + r_addr_bad !== 0) begin n_fail++; $display("FAIL misaligned_strobes: got %0d strobe cycles expected 0", r_rd_cnt + r_wr_cnt + r_addr_bad); end
        n_checks++; if (r_done_cyc !== 1 || r_err !== 1'b1) begin n_fail++; $display("FAIL misaligned_done: cyc=%0d err=%b expected 1/1", r_done_cyc, r_err); end
        n_checks++; if (r_stall0 !== 1'b1 || r_stall_done !== 1'b0) begin n_fail++; $display("FAIL misaligned_stall: c0=%b c1=%b expected 1/0", r_stall0, r_stall_done); end
        n_checks++; if (ledr !== 10'h2A5) begin n_fail++; $display("FAIL misaligned_ledr: got %h expected 2a5", ledr); end
    endtask

    task automatic test_ack_at_timeout();
        force_data = 32'hDEAD_BEEF;
        do_access(1'b0, 32'h5000_0000, 32'h0, 16, 1'b0);
        force_data = 32'h0;
        n_checks++; if (r_rd_cnt !== 16) begin n_fail++; $display("FAIL ack_timeout_strobes: rd=%0d expected 16", r_rd_cnt); end
        n_checks++; if (r_done_cyc !== 17 || r_err !== 1'b0) begin n_fail++; $display("FAIL ack_timeout_done: cyc=%0d err=%b expected 17/0", r_done_cyc, r_err); end
        n_checks++; if (r_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ack_timeout_rdata: got %h expected deadbeef", r_rdata); end
    endtask

    task automatic test_ack_outside_bus();
        int bad = 0;
        @(posedge clk); #1;
        force_ack = 1'b1; force_data = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (cpu_done || cpu_err || read_s || write_s || cpu_stall || cpu_rdata !== 32'h0) bad++;
        end
        force_ack = 1'b0; force_data = 32'h0;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ack_idle_ignored: %0d active cycles expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        int wr_cyc = 0, rd_cyc = 0, d1 = 0, d2 = 0, strobes = 0;
        logic [31:0] rd2 = 32'hx;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = LED_ADDR; cpu_wdata = 32'h0000_0135;
        for (int c = 1; c <= 30 && d2 == 0; c++) begin
            @(posedge clk); #1;
            if (read_s || write_s) strobes++;
            if (write_s && wr_cyc == 0) wr_cyc = c;
            if (read_s && rd_cyc == 0) rd_cyc = c;
            if (cpu_done && d1 == 0) begin
                d1 = c; cpu_we = 1'b0;
            end else if (cpu_done) begin
                d2 = c; rd2 = cpu_rdata; cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        n_checks++; if (wr_cyc !== 1 || d1 !== 2) begin n_fail++; $display("FAIL b2b_first: wr=%0d done=%0d expected 1/2", wr_cyc, d1); end
        n_checks++; if (rd_cyc !== 4 || d2 !== 5) begin n_fail++; $display("FAIL b2b_second: rd=%0d done=%0d expected 4/5", rd_cyc, d2); end
        n_checks++; if (strobes !== 2) begin n_fail++; $display("FAIL b2b_strobes: got %0d expected 2", strobes); end
        n_checks++; if (rd2 !== 32'h0000_0135) begin n_fail++; $display("FAIL b2b_rdata: got %h expected 00000135", rd2); end
    endtask

    task automatic test_reset_in_bus();
        int dones = 0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5000_0000;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (read_s !== 1'b1 || addr_s !== 32'h5000_0000) begin n_fail++; $display("FAIL rst_bus_active: rd=%b addr=%h expected 1/50000000", read_s, addr_s); end
        #2; cpu_req = 1'b0; rst_n = 1'b0; #1;
        n_checks++; if (read_s !== 1'b0 || write_s !== 1'b0 || addr_s !== 32'h0 || cpu_stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_bus_drop: rd=%b wr=%b addr=%h stall=%b expected 0", read_s, write_s, addr_s, cpu_stall);
        end
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (cpu_done) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d pulses expected 0", dones); end
        do_access(1'b0, LED_ADDR, 32'h0, 0, 1'b0);
        n_checks++; if (r_done_cyc !== 2 || r_err !== 1'b0 || r_rdata !== 32'h0000_0135) begin
            n_fail++; $display("FAIL rst_recover: cyc=%0d err=%b rdata=%h expected 2/0/00000135", r_done_cyc, r_err, r_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_timeout();
        test_misaligned();
        test_ack_at_timeout();
        test_ack_outside_bus();
        test_back_to_back();
        test_reset_in_bus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
